proc_mem_loader: RTL

Host-side programming stage directly upstream of the pipelined datapath. It converts level-valued software registers into single-cycle instruction-memory and data-memory write/read strobes. It holds the processor in reset while loading, and returns status and read-back data for the hardware register path. Command handshake is a toggle bit, because software registers are levels and carry no write pulse.

---
 rtl/proc_mem_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/proc_mem_loader.sv
// Host loader: toggle-handshaked software commands -> one-cycle imem/dmem strobes; optional PROC_MEM_LOADER_AUTOINC_EN address pointers.
// Latency toggle->seq_ack: NOP/rejected 2, writes 3, reads 3+RD_LATENCY cycles.
// Backpressure: a toggle seen while not IDLE stays pending and is taken on the return to IDLE.
module proc_mem_loader #(
  parameter int IMEM_ADDR_WIDTH = 9,
  parameter int DMEM_ADDR_WIDTH = 8,
  parameter int RD_LATENCY      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                sw_cmd,
  input  logic [31:0]                sw_addr,
  input  logic [31:0]                sw_data_lo,
  input  logic [31:0]                sw_data_hi,
  output logic                       imem_wr_en,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wr_data,
  output logic                       dmem_wr_en,
  output logic                       dmem_rd_en,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [63:0]                dmem_wr_data,
  input  logic [63:0]                dmem_rd_data,
  output logic                       proc_reset,
  output logic [31:0]                status,
  output logic [31:0]                rd_data_lo,
  output logic [31:0]                rd_data_hi
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_DONE} state_t;

  localparam logic [1:0] OP_NOP     = 2'd0;
  localparam logic [1:0] OP_IMEM_WR = 2'd1;
  localparam logic [1:0] OP_DMEM_WR = 2'd2;
  localparam logic [1:0] OP_DMEM_RD = 2'd3;
  localparam logic [2:0] LAT_LAST   = 3'(RD_LATENCY - 1);

  state_t      state, state_nxt;
  logic        seq_seen, seq_ack, addr_err, busy;
  logic [15:0] cmd_cnt;
  logic [1:0]  op_q;
  logic        go_q;
  logic [2:0]  lat_cnt;

  logic [1:0]  op_in;
  logic        new_cmd, is_wr, skip, oor, issue_ok, use_ptr;
  logic        imem_oor, dmem_oor;
  logic [IMEM_ADDR_WIDTH-1:0] imem_eff;
  logic [DMEM_ADDR_WIDTH-1:0] dmem_eff;
  logic        unused_cmd;

  assign unused_cmd = ^{sw_cmd[30:9], sw_cmd[7:2]};

  assign op_in    = sw_cmd[1:0];
  assign new_cmd  = (state == S_IDLE) && (sw_cmd[31] != seq_seen);
  assign is_wr    = (op_in == OP_IMEM_WR) || (op_in == OP_DMEM_WR);
  // A running program (proc_reset low) must never be overwritten.
  assign skip     = (op_in == OP_NOP) || (is_wr && !proc_reset);
  assign imem_oor = |sw_addr[31:IMEM_ADDR_WIDTH];
  assign dmem_oor = |sw_addr[31:DMEM_ADDR_WIDTH];
  assign oor      = !use_ptr && ((op_in == OP_IMEM_WR) ? imem_oor : dmem_oor);
  assign issue_ok = !skip && !oor;

`ifdef PROC_MEM_LOADER_AUTOINC_EN
  logic [IMEM_ADDR_WIDTH-1:0] imem_ptr;
  logic [DMEM_ADDR_WIDTH-1:0] dmem_ptr;

  assign use_ptr  = sw_cmd[2];
  assign imem_eff = use_ptr ? imem_ptr : sw_addr[IMEM_ADDR_WIDTH-1:0];
  assign dmem_eff = use_ptr ? dmem_ptr : sw_addr[DMEM_ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_ptr <= '0;
      dmem_ptr <= '0;
    end else if (new_cmd && issue_ok) begin
      if (op_in == OP_IMEM_WR) imem_ptr <= imem_eff + IMEM_ADDR_WIDTH'(1);
      else                     dmem_ptr <= dmem_eff + DMEM_ADDR_WIDTH'(1);
    end
  end
`else
  assign use_ptr  = 1'b0;
  assign imem_eff = sw_addr[IMEM_ADDR_WIDTH-1:0];
  assign dmem_eff = sw_addr[DMEM_ADDR_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    imem_wr_en = 1'b0;
    dmem_wr_en = 1'b0;
    dmem_rd_en = 1'b0;
    busy       = 1'b0;
    unique case (state)
      S_IDLE:    if (new_cmd) state_nxt = skip ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        busy       = 1'b1;
        // Strobes are masked by reset so an abort never reaches memory.
        imem_wr_en = go_q && (op_q == OP_IMEM_WR) && !reset;
        dmem_wr_en = go_q && (op_q == OP_DMEM_WR) && !reset;
        dmem_rd_en = go_q && (op_q == OP_DMEM_RD) && !reset;
        state_nxt  = (go_q && op_q == OP_DMEM_RD) ? S_WAIT_RD : S_DONE;
      end
      S_WAIT_RD: begin
        busy = 1'b1;
        if (lat_cnt == LAT_LAST) state_nxt = S_DONE;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    proc_reset <= reset | sw_cmd[8];
    if (reset) begin
      seq_seen     <= sw_cmd[31];
      seq_ack      <= 1'b0;
      addr_err     <= 1'b0;
      cmd_cnt      <= '0;
      op_q         <= OP_NOP;
      go_q         <= 1'b0;
      lat_cnt      <= '0;
      imem_addr    <= '0;
      imem_wr_data <= '0;
      dmem_addr    <= '0;
      dmem_wr_data <= '0;
      rd_data_lo   <= '0;
      rd_data_hi   <= '0;
    end else begin
      if (new_cmd) begin
        seq_seen <= sw_cmd[31];
        op_q     <= op_in;
        go_q     <= issue_ok;
        if (!skip) addr_err <= oor;
        if (op_in == OP_IMEM_WR) begin
          imem_addr    <= imem_eff;
          imem_wr_data <= sw_data_lo;
        end else if (op_in != OP_NOP) begin
          dmem_addr    <= dmem_eff;
          dmem_wr_data <= {sw_data_hi, sw_data_lo};
        end
      end
      if (state == S_ISSUE)        lat_cnt <= '0;
      else if (state == S_WAIT_RD) lat_cnt <= lat_cnt + 3'd1;
      if (state == S_WAIT_RD && lat_cnt == LAT_LAST) begin
        rd_data_hi <= dmem_rd_data[63:32];
        rd_data_lo <= dmem_rd_data[31:0];
      end
      if (state == S_DONE) begin
        seq_ack <= seq_seen;
        cmd_cnt <= cmd_cnt + 16'd1;
      end
    end
  end

  assign status = {seq_ack, busy, addr_err, proc_reset, 12'h000, cmd_cnt};

endmodule
